terminal_glyph_scheduler: RTL and testbench

Sequences per-pixel rendering of the 64×40 character terminal from one shared glyph ROM and one shared palette ROM, replacing per-character ROM copies. It sits between the video timing generator and the HDMI pixel path:
- tracks the current cell and in-cell offset with counters (no dividers);
- fetches the character code from the terminal character buffer, then the glyph palette index, then the RGB colour;
- delivers colour aligned with delayed hcount/vcount/active sideband.

---
 rtl/term_pkg.sv | 31 +++
 rtl/pixel_delay_pipe.sv | 35 +++
 rtl/terminal_glyph_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_terminal_glyph_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// term_pkg: shared geometry constants and the pipeline sideband record for
// terminal_glyph_scheduler.
package term_pkg;

   localparam int CHAR_W       = 20;
   localparam int CHAR_H       = 18;
   localparam int GRID_COLS    = 64;
   localparam int GRID_ROWS    = 40;
   localparam int GLYPH_PIXELS = CHAR_W * CHAR_H;
   localparam int NUM_GLYPHS   = 26;

   // Counter widths: col/row need one extra code for the saturated "out of grid" value.
   localparam int X_W   = 5;
   localparam int Y_W   = 5;
   localparam int COL_W = 7;
   localparam int ROW_W = 6;

   typedef struct packed {
      logic [10:0]    hcount;
      logic [9:0]     vcount;
      logic           active;
      logic           in_grid;
      logic           blank;
      logic [X_W-1:0] x_off;
      logic [Y_W-1:0] y_off;
      logic           cursor_hit;
   } sideband_t;

   localparam int SB_W = $bits(sideband_t);

endpackage

// File: rtl/pixel_delay_pipe.sv
// pixel_delay_pipe: DEPTH-stage register chain that carries pixel sideband
// alongside a ROM read so it lines up with the returned data.
module pixel_delay_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] data_reg;
         if (gi == 0) begin : g_first
            // First stage captures the incoming sideband.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) data_reg <= '0;
               else     data_reg <= d;
            end
         end else begin : g_next
            // Later stages shift the previous stage along.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) data_reg <= '0;
               else     data_reg <= g_stage[gi-1].data_reg;
            end
         end
      end
   endgenerate

   assign q = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/terminal_glyph_scheduler.sv
// terminal_glyph_scheduler: walks the 64x40 character grid with counters and
// fetches char code -> glyph palette index -> RGB through shared ROMs, with
// the video sideband delayed to match (10-cycle fixed latency).
// Optional feature macro: CURSOR_EN (blinking inverted-colour cursor cell).
module terminal_glyph_scheduler #(
   parameter int CHAR_W       = term_pkg::CHAR_W,
   parameter int CHAR_H       = term_pkg::CHAR_H,
   parameter int GRID_COLS    = term_pkg::GRID_COLS,
   parameter int GRID_ROWS    = term_pkg::GRID_ROWS,
   parameter int NUM_GLYPHS   = term_pkg::NUM_GLYPHS,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        active_draw_in,
   output logic [11:0] char_addr_out,
   input  logic [4:0]  char_data_in,
   output logic [13:0] glyph_addr_out,
   input  logic [7:0]  glyph_data_in,
   output logic [7:0]  palette_addr_out,
   input  logic [23:0] palette_data_in,
`ifdef CURSOR_EN
   input  logic [5:0]  cursor_col_in,
   input  logic [5:0]  cursor_row_in,
`endif
   output logic [7:0]  red_out,
   output logic [7:0]  green_out,
   output logic [7:0]  blue_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        active_draw_out
);
   import term_pkg::*;

   localparam int GLYPH_SIZE = CHAR_W * CHAR_H;

   logic [X_W-1:0]   x_off_reg, x_off_next;
   logic [COL_W-1:0] col_reg, col_next;
   logic [Y_W-1:0]   y_off_reg, y_off_next;
   logic [ROW_W-1:0] row_reg, row_next;
   logic             synced_reg, synced_next;
   logic             line_start, frame_start;
   logic             blink_phase_next;
   sideband_t        sb0, sb3, sb3_tagged, sb6, sb9;
   logic [23:0]      rgb_next;

   assign line_start  = (hcount_in == '0);
   assign frame_start = line_start && (vcount_in == '0);

   // Position of the current pixel: derived from the previous pixel's counters.
   always_comb begin
      x_off_next = x_off_reg;
      col_next   = col_reg;
      y_off_next = y_off_reg;
      row_next   = row_reg;
      if (line_start) begin
         x_off_next = '0;
         col_next   = '0;
         if (vcount_in == '0) begin
            y_off_next = '0;
            row_next   = '0;
         end else if (y_off_reg == Y_W'(CHAR_H - 1)) begin
            y_off_next = '0;
            if (row_reg != ROW_W'(GRID_ROWS)) row_next = row_reg + 1'b1;
         end else begin
            y_off_next = y_off_reg + 1'b1;
         end
      end else if (x_off_reg == X_W'(CHAR_W - 1)) begin
         x_off_next = '0;
         if (col_reg != COL_W'(GRID_COLS)) col_next = col_reg + 1'b1;
      end else begin
         x_off_next = x_off_reg + 1'b1;
      end
      // Until a line start is seen after reset the counters mean nothing.
      synced_next = synced_reg | line_start;
   end

`ifdef CURSOR_EN
   logic [15:0] frame_cnt_reg, frame_cnt_next;
   logic        blink_phase_reg;

   // Frame counter runs 1..BLINK_FRAMES; each wrap flips the blink phase.
   always_comb begin
      frame_cnt_next   = frame_cnt_reg;
      blink_phase_next = blink_phase_reg;
      if (frame_start) begin
         if (frame_cnt_reg == 16'(BLINK_FRAMES)) begin
            frame_cnt_next   = 16'd1;
            blink_phase_next = ~blink_phase_reg;
         end else begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
         end
      end
   end

   // Blink state registers.
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         frame_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
      end else begin
         frame_cnt_reg   <= frame_cnt_next;
         blink_phase_reg <= blink_phase_next;
      end
   end
`else
   logic unused_cfg;
   assign blink_phase_next = 1'b0;
   assign unused_cfg       = (BLINK_FRAMES == 0) ^ frame_start;
`endif

   // Sideband record for the pixel being sampled this cycle.
   always_comb begin
      sb0         = '0;
      sb0.hcount  = hcount_in;
      sb0.vcount  = vcount_in;
      sb0.active  = active_draw_in;
      sb0.in_grid = synced_next && active_draw_in &&
                    (int'(col_next) < GRID_COLS) && (int'(row_next) < GRID_ROWS);
      sb0.x_off   = x_off_next;
      sb0.y_off   = y_off_next;
`ifdef CURSOR_EN
      sb0.cursor_hit = blink_phase_next && (row_next == cursor_row_in) &&
                       (col_next == {1'b0, cursor_col_in});
`endif
   end

   // Counters and the character buffer address (cycle 1).
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         x_off_reg     <= '0;
         col_reg       <= '0;
         y_off_reg     <= '0;
         row_reg       <= '0;
         synced_reg    <= 1'b0;
         char_addr_out <= '0;
      end else begin
         x_off_reg     <= x_off_next;
         col_reg       <= col_next;
         y_off_reg     <= y_off_next;
         row_reg       <= row_next;
         synced_reg    <= synced_next;
         char_addr_out <= 12'(int'(row_next) * GRID_COLS + int'(col_next));
      end
   end

   pixel_delay_pipe #(.WIDTH(SB_W), .DEPTH(3)) u_pipe_char (
      .clk(pixel_clk_in), .rst(rst_in), .d(sb0), .q(sb3)
   );

   // Tag out-of-range codes as blank once the character code arrives.
   always_comb begin
      sb3_tagged       = sb3;
      sb3_tagged.blank = (int'(char_data_in) >= NUM_GLYPHS);
   end

   // Glyph ROM address (cycle 4); blank codes park the address at 0.
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in)                glyph_addr_out <= '0;
      else if (sb3_tagged.blank) glyph_addr_out <= '0;
      else glyph_addr_out <= 14'(int'(char_data_in) * GLYPH_SIZE +
                                 int'(sb3.y_off) * CHAR_W + int'(sb3.x_off));
   end

   pixel_delay_pipe #(.WIDTH(SB_W), .DEPTH(3)) u_pipe_glyph (
      .clk(pixel_clk_in), .rst(rst_in), .d(sb3_tagged), .q(sb6)
   );

   // Palette ROM address (cycle 7).
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) palette_addr_out <= '0;
      else        palette_addr_out <= glyph_data_in;
   end

   pixel_delay_pipe #(.WIDTH(SB_W), .DEPTH(3)) u_pipe_palette (
      .clk(pixel_clk_in), .rst(rst_in), .d(sb6), .q(sb9)
   );

   // Final colour: black outside the grid or for blank cells, cursor inverts.
   always_comb begin
      rgb_next = 24'd0;
      if (sb9.in_grid && !sb9.blank) rgb_next = palette_data_in;
`ifdef CURSOR_EN
      if (sb9.in_grid && sb9.cursor_hit) rgb_next = ~rgb_next;
`endif
   end

   // Registered colour and aligned sideband (cycle 10).
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         red_out         <= '0;
         green_out       <= '0;
         blue_out        <= '0;
         hcount_out      <= '0;
         vcount_out      <= '0;
         active_draw_out <= 1'b0;
      end else begin
         red_out         <= rgb_next[23:16];
         green_out       <= rgb_next[15:8];
         blue_out        <= rgb_next[7:0];
         hcount_out      <= sb9.hcount;
         vcount_out      <= sb9.vcount;
         active_draw_out <= sb9.active;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{sb3.blank, sb9.x_off, sb9.y_off, sb9.cursor_hit};

endmodule

// File: tb/tb_terminal_glyph_scheduler.sv
// tb_terminal_glyph_scheduler: random ROM contents and random line lengths,
// checked each cycle against a division-based model of the character grid.
module tb_terminal_glyph_scheduler;

   localparam int CW = 20, CH = 18, COLS = 64, ROWS = 40, NG = 26;
   localparam int BLINK_TB = 2;
   localparam int CUR_ROW = 1, CUR_COL = 2;

   logic        clk, rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        active;
   logic [11:0] char_addr;
   logic [4:0]  char_data;
   logic [13:0] glyph_addr;
   logic [7:0]  glyph_data;
   logic [7:0]  palette_addr;
   logic [23:0] palette_data;
   logic [7:0]  red, green, blue;
   logic [10:0] hcount_o;
   logic [9:0]  vcount_o;
   logic        active_o;

   logic [4:0]  charbuf [4096];
   logic [7:0]  glyph   [16384];
   logic [23:0] palette [256];
   logic [4:0]  c1;
   logic [7:0]  g1;
   logic [23:0] p1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          valid;
      int          h, v;
      bit          act, ingrid, blank;
      int          caddr, gaddr, paddr;
      logic [23:0] rgb;
   } rec_t;

   rec_t hist [16];
   int   wp = 0;
   bit   m_synced = 0;
   int   m_starts = 0;

`ifdef CURSOR_EN
   logic [5:0] cur_col, cur_row;
   assign cur_col = 6'(CUR_COL);
   assign cur_row = 6'(CUR_ROW);

   terminal_glyph_scheduler #(.BLINK_FRAMES(BLINK_TB)) dut (
`else
   terminal_glyph_scheduler dut (
`endif
      .pixel_clk_in(clk), .rst_in(rst),
      .hcount_in(hcount), .vcount_in(vcount), .active_draw_in(active),
      .char_addr_out(char_addr), .char_data_in(char_data),
      .glyph_addr_out(glyph_addr), .glyph_data_in(glyph_data),
      .palette_addr_out(palette_addr), .palette_data_in(palette_data),
`ifdef CURSOR_EN
      .cursor_col_in(cur_col), .cursor_row_in(cur_row),
`endif
      .red_out(red), .green_out(green), .blue_out(blue),
      .hcount_out(hcount_o), .vcount_out(vcount_o), .active_draw_out(active_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous ROMs / buffer with two cycles of read latency.
   always @(posedge clk) begin
      c1 <= charbuf[char_addr];
      char_data <= c1;
      g1 <= glyph[glyph_addr];
      glyph_data <= g1;
      p1 <= palette[palette_addr];
      palette_data <= p1;
   end

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (hcount_in=%0d vcount_in=%0d)",
                  name, got, exp, hcount, vcount);
      end
   endtask

   // What the pixel must look like, straight from the grid geometry.
   function automatic rec_t model_pixel(input int h, input int v, input bit act);
      rec_t r;
      int   col, row, x, y, code;
      bit   blink;
      if (h == 0) m_synced = 1'b1;
      if (h == 0 && v == 0) m_starts++;
      col = h / CW; if (col > COLS) col = COLS;
      row = v / CH; if (row > ROWS) row = ROWS;
      x = h % CW;
      y = v % CH;
      r.valid  = 1'b1;
      r.h      = h;
      r.v      = v;
      r.act    = act;
      r.ingrid = m_synced && act && col < COLS && row < ROWS;
      r.caddr  = row * COLS + col;
      code     = int'(charbuf[r.caddr]);
      r.blank  = code >= NG;
      r.gaddr  = r.blank ? 0 : code * CW * CH + y * CW + x;
      r.paddr  = int'(glyph[r.gaddr]);
      r.rgb    = (r.ingrid && !r.blank) ? palette[r.paddr] : 24'd0;
      blink    = (m_starts > 0) && ((((m_starts - 1) / BLINK_TB) % 2) == 1);
`ifdef CURSOR_EN
      if (r.ingrid && blink && row == CUR_ROW && col == CUR_COL) r.rgb = ~r.rgb;
`else
      if (blink && r.caddr < 0) r.rgb = 24'd0;
`endif
      return r;
   endfunction

   // Compare process: push the sampled pixel, then check every output 1ns later.
   always @(posedge clk) begin : compare
      rec_t r;
      if (rst) begin
         for (int i = 0; i < 16; i++) hist[i].valid = 1'b0;
         m_synced = 1'b0;
         m_starts = 0;
      end else begin
         hist[wp] = model_pixel(int'(hcount), int'(vcount), active);
         wp = (wp + 1) % 16;
      end
      #1;
      r = hist[(wp + 15) % 16];
      if (r.valid && r.ingrid) check("char_addr", char_addr, r.caddr);
      r = hist[(wp + 12) % 16];
      if (r.valid && r.ingrid) begin
         check("glyph_addr", glyph_addr, r.gaddr);
         if (r.v == 0 && r.h < 20) check("glyph_addr_cell00", glyph_addr, 1080 + r.h);
         if (r.v == 719 && r.h == 1279) check("glyph_addr_last", glyph_addr, 9359);
      end
      r = hist[(wp + 9) % 16];
      if (r.valid && r.ingrid && !r.blank) check("palette_addr", palette_addr, r.paddr);
      r = hist[(wp + 6) % 16];
      check("rgb", {red, green, blue}, r.valid ? r.rgb : 24'd0);
      check("hcount_out", hcount_o, r.valid ? r.h : 0);
      check("vcount_out", vcount_o, r.valid ? r.v : 0);
      check("active_out", active_o, r.valid ? r.act : 1'b0);
      if (r.valid && r.v >= 90 && r.v <= 107 && r.h >= 100 && r.h <= 119)
         check("rgb_blank_cell55", {red, green, blue}, 0);
      if (r.valid && r.h >= 1280) check("rgb_hblank", {red, green, blue}, 0);
   end

   task automatic drive(input int h, input int v);
      @(negedge clk);
      hcount = 11'(h);
      vcount = 10'(v);
      active = (h < 1280) && (v < 720);
   endtask

   function automatic int line_len(input int v, input bit full);
      if (full && (v == 0 || v == 17 || v == 18 || v == 90 || v == 107 || v == 719))
         return 1650;
      if (v >= 18 && v <= 35) return 64;
      return int'($urandom_range(2, 12));
   endfunction

   task automatic run_frame(input int v_first, input bit full);
      int len;
      for (int v = v_first; v < 750; v++) begin
         len = line_len(v, full);
         $display("line vcount=%0d hcount=0..%0d", v, len - 1);
         for (int h = 0; h < len; h++) drive(h, v);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rgb"}, {red, green, blue}, 0);
      check({tag, "_hcount_out"}, hcount_o, 0);
      check({tag, "_vcount_out"}, vcount_o, 0);
      check({tag, "_active_out"}, active_o, 0);
      check({tag, "_char_addr"}, char_addr, 0);
      check({tag, "_glyph_addr"}, glyph_addr, 0);
      check({tag, "_palette_addr"}, palette_addr, 0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) charbuf[i] = 5'($urandom_range(0, 31));
      for (int i = 0; i < 16384; i++) glyph[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) palette[i] = 24'($urandom);
      charbuf[0]             = 5'd3;
      charbuf[39 * 64 + 63]  = 5'd25;
      charbuf[5 * 64 + 5]    = 5'd31;
      charbuf[CUR_ROW * 64 + CUR_COL] = 5'd31;

      rst = 1'b1;
      hcount = '0;
      vcount = '0;
      active = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      $display("frame 0 after reset");
      run_frame(0, 1'b1);

      $display("reset asserted at hcount 700 of vcount 0");
      for (int h = 0; h < 700; h++) drive(h, 0);
      drive(700, 0);
      rst = 1'b1;
      #1;
      check_all_zero("midline_reset");
      for (int h = 701; h < 704; h++) drive(h, 0);
      drive(704, 0);
      rst = 1'b0;
      for (int h = 705; h < 1650; h++) drive(h, 0);
      run_frame(1, 1'b1);

`ifdef CURSOR_EN
      for (int f = 0; f < 6; f++) begin
         $display("blink frame %0d", f);
         run_frame(0, 1'b0);
      end
`endif

      for (int h = 0; h < 12; h++) drive(h, 0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
